// File: rtl/dm_pkg.sv
// Shared dot-matrix definitions: arbiter state encoding, display geometry and
// the column range check used by every writer into the controller.
package dm_pkg;

  localparam int COL_W    = 5;
  localparam int ROW_W    = 7;
  localparam int DM_NCOLS = 5;

  typedef logic [COL_W-1:0] dmCol_t;
  typedef logic [ROW_W-1:0] dmRow_t;

  typedef enum logic [3:0] {
    IDLE    = 4'b0001,
    WRITE   = 4'b0010,
    RECOVER = 4'b0100,
    REJECT  = 4'b1000
  } dmState_t;

  function automatic logic colValid(input dmCol_t col, input int ncols);
    return {{(32-COL_W){1'b0}}, col} < ncols;
  endfunction

endpackage

// File: rtl/dm_write_arbiter_if.sv
// Two-requester write port into the dot-matrix controller; master is the
// requester/enable side, slave is the arbiter.
interface dm_write_arbiter_if;
  import dm_pkg::*;

  logic   arb_en;
  logic   req0, req1;
  dmCol_t col0, col1;
  dmRow_t row0, row1;
  logic   ack0, ack1, err;
  logic   dm_write, dm_enable, busy;
  dmCol_t dm_col_addr;
  dmRow_t dm_row;

  modport master (
    output arb_en, req0, col0, row0, req1, col1, row1,
    input  ack0, ack1, err, dm_write, dm_enable, dm_col_addr, dm_row, busy
  );

  modport slave (
    input  arb_en, req0, col0, row0, req1, col1, row1,
    output ack0, ack1, err, dm_write, dm_enable, dm_col_addr, dm_row, busy
  );

endinterface

// File: rtl/dm_write_arbiter.sv
// Round-robin arbiter serialising two column writers onto the dot-matrix
// controller, with a timed write strobe and a recovery gap after each write.
module dm_write_arbiter
  import dm_pkg::*;
#(
  parameter int WR_HOLD = 2,
  parameter int GAP     = 1,
  parameter int NCOLS   = DM_NCOLS
) (
  input  logic              clk,
  input  logic              reset,
  dm_write_arbiter_if.slave bus
);

  localparam logic [3:0] HOLD_LOAD = 4'(WR_HOLD - 1);
  localparam logic [3:0] GAP_LOAD  = 4'(GAP - 1);

  dmState_t   state, nextState;
  logic [3:0] cnt, nextCnt;
  logic       lastGrant, nextLastGrant;
  logic       ack0Q, ack1Q, nextAck0, nextAck1;
  dmCol_t     colQ, nextCol;
  dmRow_t     rowQ, nextRow;
  logic       enableQ;

  logic   anyReq;
  logic   winner;
  dmCol_t winCol;
  dmRow_t winRow;

  // Requester 1 wins when alone, or on contention when requester 0 won last.
  assign anyReq = bus.req0 | bus.req1;
  assign winner = bus.req1 & (~bus.req0 | ~lastGrant);
  assign winCol = winner ? bus.col1 : bus.col0;
  assign winRow = winner ? bus.row1 : bus.row0;

  always_comb begin
    // NOTE: every target gets a default first so no path leaves it unassigned and a latch is never inferred.
    nextState     = state;
    nextCnt       = cnt;
    nextLastGrant = lastGrant;
    nextAck0      = 1'b0;
    nextAck1      = 1'b0;
    nextCol       = colQ;
    nextRow       = rowQ;

    unique case (state)
      IDLE: begin
        if (bus.arb_en && anyReq) begin
          nextLastGrant = winner;
          nextAck0      = ~winner;
          nextAck1      = winner;
          if (colValid(winCol, NCOLS)) begin
            nextState = WRITE;
            nextCnt   = HOLD_LOAD;
            nextCol   = winCol;
            nextRow   = winRow;
          end else begin
            nextState = REJECT;
            nextCnt   = '0;
          end
        end
      end
      WRITE: begin
        if (cnt == 4'd0) begin
          if (GAP == 0) begin
            nextState = IDLE;
          end else begin
            nextState = RECOVER;
            nextCnt   = GAP_LOAD;
          end
        end else begin
          nextCnt = cnt - 4'd1;
        end
      end
      RECOVER: begin
        if (cnt == 4'd0) nextState = IDLE;
        else             nextCnt   = cnt - 4'd1;
      end
      REJECT:  nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together from pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      cnt       <= '0;
      lastGrant <= 1'b1;
      ack0Q     <= 1'b0;
      ack1Q     <= 1'b0;
      colQ      <= '0;
      rowQ      <= '0;
      enableQ   <= 1'b0;
    end else begin
      state     <= nextState;
      cnt       <= nextCnt;
      lastGrant <= nextLastGrant;
      ack0Q     <= nextAck0;
      ack1Q     <= nextAck1;
      colQ      <= nextCol;
      rowQ      <= nextRow;
      enableQ   <= bus.arb_en;
    end
  end

  // Strobe, error and busy decode straight from state so reset kills them at once.
  assign bus.ack0        = ack0Q;
  assign bus.ack1        = ack1Q;
  assign bus.err         = (state == REJECT);
  assign bus.dm_write    = (state == WRITE);
  assign bus.busy        = (state != IDLE);
  assign bus.dm_enable   = enableQ;
  assign bus.dm_col_addr = colQ;
  assign bus.dm_row      = rowQ;

endmodule

// File: tb/tb_dm_write_arbiter.sv
// Drives a default arbiter and a WR_HOLD=1/GAP=0 arbiter with shared stimulus
// and compares both against a transaction-level timing model.
module tb_dm_write_arbiter;
  import dm_pkg::*;

  logic clk;
  logic reset;
  int   cyc;
  int   vecCount;
  int   missCount;

  dm_write_arbiter_if busA();
  dm_write_arbiter_if busB();

  dm_write_arbiter dutA (
    .clk   (clk),
    .reset (reset),
    .bus   (busA.slave)
  );

  dm_write_arbiter #(.WR_HOLD(1), .GAP(0)) dutB (
    .clk   (clk),
    .reset (reset),
    .bus   (busB.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: per DUT, the edge of the last grant, its kind, and the first IDLE cycle after it.
  int     holdP[2] = '{2, 1};
  int     gapP[2]  = '{1, 0};
  int     grantCyc[2];
  int     freeCyc[2];
  int     lastWinner[2];
  int     winnerNow[2];
  bit     isWrite[2];
  bit     enExp[2];
  dmCol_t wCol[2];
  dmRow_t wRow[2];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vecCount++;
    if (got !== exp) begin
      missCount++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic drive(input logic en, input logic r0, input dmCol_t c0, input dmRow_t w0,
                       input logic r1, input dmCol_t c1, input dmRow_t w1);
    busA.arb_en = en; busA.req0 = r0; busA.col0 = c0; busA.row0 = w0;
    busA.req1   = r1; busA.col1 = c1; busA.row1 = w1;
    busB.arb_en = en; busB.req0 = r0; busB.col0 = c0; busB.row0 = w0;
    busB.req1   = r1; busB.col1 = c1; busB.row1 = w1;
  endtask

  task automatic modelReset();
    for (int d = 0; d < 2; d++) begin
      grantCyc[d]   = -100;
      freeCyc[d]    = -100;
      lastWinner[d] = 1;
      winnerNow[d]  = 0;
      isWrite[d]    = 1'b0;
      enExp[d]      = 1'b0;
      wCol[d]       = '0;
      wRow[d]       = '0;
    end
  endtask

  // Applied at edge cyc using the inputs that were stable before it.
  task automatic modelEdge(input int d);
    int w;
    if ((cyc - 1 >= freeCyc[d]) && busA.arb_en && (busA.req0 || busA.req1)) begin
      if (busA.req0 && busA.req1) w = 1 - lastWinner[d];
      else                        w = busA.req1 ? 1 : 0;
      lastWinner[d] = w;
      winnerNow[d]  = w;
      grantCyc[d]   = cyc;
      wCol[d]       = (w == 1) ? busA.col1 : busA.col0;
      wRow[d]       = (w == 1) ? busA.row1 : busA.row0;
      isWrite[d]    = (int'(wCol[d]) < DM_NCOLS);
      freeCyc[d]    = isWrite[d] ? cyc + holdP[d] + gapP[d] : cyc + 1;
    end
    enExp[d] = busA.arb_en;
  endtask

  task automatic checkDut(input int d, input string nm, input logic a0, input logic a1,
                          input logic er, input logic wr, input logic en, input logic bz,
                          input dmCol_t col, input dmRow_t row);
    bit first, expWr, expBusy;
    first   = (cyc == grantCyc[d]);
    expWr   = isWrite[d] && (cyc >= grantCyc[d]) && (cyc < grantCyc[d] + holdP[d]);
    expBusy = (cyc >= grantCyc[d]) && (cyc < freeCyc[d]);
    check({nm, ".ack0"},      32'(a0), 32'(first && winnerNow[d] == 0));
    check({nm, ".ack1"},      32'(a1), 32'(first && winnerNow[d] == 1));
    check({nm, ".err"},       32'(er), 32'(first && !isWrite[d]));
    check({nm, ".dm_write"},  32'(wr), 32'(expWr));
    check({nm, ".busy"},      32'(bz), 32'(expBusy));
    check({nm, ".dm_enable"}, 32'(en), 32'(enExp[d]));
    if (expWr) begin
      check({nm, ".dm_col_addr"}, 32'(col), 32'(wCol[d]));
      check({nm, ".dm_row"},      32'(row), 32'(wRow[d]));
    end
  endtask

  task automatic checkAll();
    checkDut(0, "A", busA.ack0, busA.ack1, busA.err, busA.dm_write, busA.dm_enable,
             busA.busy, busA.dm_col_addr, busA.dm_row);
    checkDut(1, "B", busB.ack0, busB.ack1, busB.err, busB.dm_write, busB.dm_enable,
             busB.busy, busB.dm_col_addr, busB.dm_row);
  endtask

  task automatic checkResetState(input string tag);
    check({tag, ".A.outs"}, 32'({busA.ack0, busA.ack1, busA.err, busA.dm_write,
                                 busA.dm_enable, busA.busy}), 32'd0);
    check({tag, ".A.addr"}, 32'({busA.dm_col_addr, busA.dm_row}), 32'd0);
    check({tag, ".B.outs"}, 32'({busB.ack0, busB.ack1, busB.err, busB.dm_write,
                                 busB.dm_enable, busB.busy}), 32'd0);
    check({tag, ".B.addr"}, 32'({busB.dm_col_addr, busB.dm_row}), 32'd0);
  endtask

  task automatic step();
    @(posedge clk);
    cyc++;
    modelEdge(0);
    modelEdge(1);
    @(negedge clk);
    checkAll();
  endtask

  initial begin
    cyc = 0; vecCount = 0; missCount = 0;
    modelReset();
    drive(1'b1, 1'b1, 5'd2, 7'h12, 1'b1, 5'd3, 7'h13);
    reset = 1'b1;
    #2 reset = 1'b0;
    #1 checkResetState("por");
    repeat (2) begin
      @(posedge clk);
      cyc++;
    end
    @(negedge clk);
    checkResetState("por_hold");
    drive(1'b0, 1'b0, 5'd0, 7'h00, 1'b0, 5'd0, 7'h00);
    reset = 1'b1;
    step();

    // Single write from requester 0, dropped in its ack cycle.
    drive(1'b1, 1'b1, 5'd3, 7'h55, 1'b0, 5'd0, 7'h00);
    step();
    drive(1'b1, 1'b0, 5'd3, 7'h55, 1'b0, 5'd0, 7'h00);
    repeat (6) step();

    // Both held: grants alternate.
    drive(1'b1, 1'b1, 5'd1, 7'h11, 1'b1, 5'd2, 7'h22);
    repeat (16) step();
    drive(1'b1, 1'b0, 5'd0, 7'h00, 1'b0, 5'd0, 7'h00);
    repeat (6) step();

    // Out-of-range column from requester 1, then contention.
    drive(1'b1, 1'b0, 5'd0, 7'h00, 1'b1, 5'd7, 7'h7f);
    step();
    drive(1'b1, 1'b1, 5'd4, 7'h0a, 1'b1, 5'd0, 7'h50);
    repeat (8) step();
    drive(1'b1, 1'b0, 5'd0, 7'h00, 1'b0, 5'd0, 7'h00);
    repeat (6) step();

    // Enable dropped during a write; pending request waits.
    drive(1'b1, 1'b1, 5'd2, 7'h33, 1'b0, 5'd0, 7'h00);
    step();
    drive(1'b0, 1'b1, 5'd2, 7'h33, 1'b0, 5'd0, 7'h00);
    repeat (8) step();
    drive(1'b1, 1'b1, 5'd2, 7'h33, 1'b0, 5'd0, 7'h00);
    repeat (4) step();
    drive(1'b1, 1'b0, 5'd0, 7'h00, 1'b0, 5'd0, 7'h00);
    repeat (6) step();

    // Reset in the second write cycle, with both requests held through it.
    drive(1'b1, 1'b1, 5'd1, 7'h44, 1'b0, 5'd0, 7'h00);
    step();
    step();
    drive(1'b1, 1'b1, 5'd1, 7'h44, 1'b1, 5'd3, 7'h66);
    reset = 1'b0;
    #1 checkResetState("mid_write");
    modelReset();
    @(posedge clk);
    cyc++;
    #1 checkResetState("in_reset");
    @(negedge clk);
    reset = 1'b1;
    step();
    drive(1'b1, 1'b0, 5'd0, 7'h00, 1'b0, 5'd0, 7'h00);
    repeat (6) step();

    // Randomized traffic.
    repeat (1500) begin
      drive($urandom_range(0, 9) != 0,
            1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), 7'($urandom),
            1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), 7'($urandom));
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
